// File: rtl/cla_adder.sv
// cla_adder: two's-complement carry-lookahead adder with one output register stage.
//
// The combinational core works in two levels:
//   - 4-bit blocks, each with flattened sum-of-products carries and group G/P terms
//   - a second-level unit that gives the carry into every block from G/P and cin
// Neither level ripples.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset; clears sum, cout and of
//   a, b  - WIDTH-bit operands, two's complement
//   cin   - carry-in at bit 0
//   sum   - registered (a + b + cin) mod 2^WIDTH
//   cout  - registered unsigned carry out of bit WIDTH-1
//   of    - registered signed overflow (carry into MSB xor carry out of MSB)
//
// WIDTH must be a multiple of 4.
module cla_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             of
);

   localparam int unsigned NumBlk = WIDTH / 4;

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [NumBlk-1:0] grp_g;
   logic [NumBlk-1:0] grp_p;
   logic [NumBlk:0]   blk_c;   // blk_c[j] is the carry into block j
   logic [WIDTH:0]    c;       // c[i] is the carry into bit i

   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;
   logic             of_d, of_q;

   assign g = a & b;
   assign p = a ^ b;

   // Group generate/propagate for each 4-bit block.
   always_comb begin
      grp_g = '0;
      grp_p = '0;
      for (int j = 0; j < int'(NumBlk); j++) begin
         grp_g[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         grp_p[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
      end
   end

   // Second-level lookahead: each block carry is an independent OR of product terms
   // built only from group G/P and cin, so no block waits on its neighbour's carry.
   always_comb begin
      logic prod;
      logic acc;
      blk_c    = '0;
      blk_c[0] = cin;
      for (int j = 1; j <= int'(NumBlk); j++) begin
         prod = cin;
         for (int m = 0; m < j; m++) begin
            prod = prod & grp_p[m];
         end
         acc = prod;
         for (int k = 0; k < j; k++) begin
            prod = grp_g[k];
            for (int m = k + 1; m < j; m++) begin
               prod = prod & grp_p[m];
            end
            acc = acc | prod;
         end
         blk_c[j] = acc;
      end
   end

   // Bit carries inside each block, two-level form from the block carry-in.
   always_comb begin
      c = '0;
      for (int j = 0; j < int'(NumBlk); j++) begin
         c[4*j]   = blk_c[j];
         c[4*j+1] = g[4*j] | (p[4*j] & blk_c[j]);
         c[4*j+2] = g[4*j+1]
                  | (p[4*j+1] & g[4*j])
                  | (p[4*j+1] & p[4*j] & blk_c[j]);
         c[4*j+3] = g[4*j+2]
                  | (p[4*j+2] & g[4*j+1])
                  | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & blk_c[j]);
      end
      c[WIDTH] = blk_c[NumBlk];
   end

   always_comb begin
      sum_d  = p ^ c[WIDTH-1:0];
      cout_d = c[WIDTH];
      of_d   = c[WIDTH] ^ c[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         of_q   <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
         of_q   <= of_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign of   = of_q;

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: directed vectors with literal expectations,
// a reset-mid-stream sequence, and random vectors checked every cycle against an
// arithmetic reference model.
module tb_cla_adder;

   localparam int unsigned W = 32;

   logic         clk;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] sum;
   logic         cout;
   logic         of;

   int vectors;
   int miscompares;

   cla_adder #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout),
      .of   (of)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: (W+1)-bit addition; overflow from operand/result signs.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc);
      logic [W:0] full;
      logic       ovf;
      full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      ovf  = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
      return {ovf, full};  // {of, cout, sum}
   endfunction

   // Expected outputs captured at each edge; checked on the following falling edge.
   logic [W-1:0] exp_sum;
   logic         exp_cout;
   logic         exp_of;
   logic         exp_valid = 1'b0;

   always @(posedge clk) begin
      logic [W+1:0] m;
      m = model(a, b, cin);
      if (rst) begin
         exp_sum  <= '0;
         exp_cout <= 1'b0;
         exp_of   <= 1'b0;
      end else begin
         exp_sum  <= m[W-1:0];
         exp_cout <= m[W];
         exp_of   <= m[W+1];
      end
      exp_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (exp_valid) begin
         vectors++;
         if (sum !== exp_sum || cout !== exp_cout || of !== exp_of) begin
            miscompares++;
            $display("FAIL model t=%0t a=%h b=%h cin=%b: got sum=%h cout=%b of=%b want sum=%h cout=%b of=%b",
                     $time, a, b, cin, sum, cout, of, exp_sum, exp_cout, exp_of);
         end
      end
   end

   // Literal check of the registered outputs, shortly after an edge.
   task automatic check_lit(input string name, input logic [W-1:0] es, input logic ec,
                            input logic eo);
      vectors++;
      if (sum !== es || cout !== ec || of !== eo) begin
         miscompares++;
         $display("FAIL %s: got sum=%h cout=%b of=%b want sum=%h cout=%b of=%b",
                  name, sum, cout, of, es, ec, eo);
      end
   endtask

   // Drive one operand set, check the result one edge later, and pin the model to it.
   task automatic vec(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic vc, input logic [W-1:0] es, input logic ec, input logic eo);
      logic [W+1:0] m;
      @(negedge clk);
      a   = va;
      b   = vb;
      cin = vc;
      m   = model(va, vb, vc);
      vectors++;
      if (m !== {eo, ec, es}) begin
         miscompares++;
         $display("FAIL %s_model: got %h want %h", name, m, {eo, ec, es});
      end
      @(posedge clk);
      #1;
      check_lit(name, es, ec, eo);
   endtask

   initial begin
      rst = 1'b1;
      a   = 32'h1234_5678;
      b   = 32'h1111_1111;
      cin = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_lit("reset_state", 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors, applied back-to-back on consecutive cycles.
      vec("pos_ovf",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
      vec("neg_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      vec("neg_neg",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
      vec("mixed",     32'h1234_5678, 32'h8000_0000, 1'b0, 32'h9234_5678, 1'b0, 1'b0);
      vec("cin_path",  32'h1234_5678, 32'h1234_5670, 1'b1, 32'h2468_ACE9, 1'b0, 1'b0);
      vec("blk_carry", 32'hFFFF_F999, 32'h0000_0111, 1'b0, 32'hFFFF_FAAA, 1'b0, 1'b0);
      vec("small_cin", 32'h0000_0420, 32'h0000_0420, 1'b1, 32'h0000_0841, 1'b0, 1'b0);
      vec("small",     32'h0000_0123, 32'h0000_0123, 1'b0, 32'h0000_0246, 1'b0, 1'b0);
      vec("long_chain",32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      vec("cin_ovf",   32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
      vec("zero",      32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
      vec("mid_chain", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

      // Reset mid-stream while a nonzero result is held.
      vec("pre_reset", 32'h1000_0001, 32'h2000_0002, 1'b1, 32'h3000_0004, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_lit("reset_mid", 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_lit("post_reset", 32'h3000_0004, 1'b0, 1'b0);

      // Random vectors, one per cycle, checked by the model process.
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         case ($urandom_range(0, 7))
            0:       a = 32'hFFFF_FFFF;
            1:       a = 32'h7FFF_FFFF;
            2:       a = 32'h8000_0000;
            default: a = $urandom;
         endcase
         b   = ($urandom_range(0, 7) == 0) ? ~a : $urandom;
         cin = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
